// File: rtl/victim_way_tracker.sv
// victim_way_tracker: per-set LRU victim choice for a 2-way cache, frozen across the evict/fill sequence.
// Defining VICTIM_STATS_EN adds saturating hit/miss/evict counters.
module victim_way_tracker #(
    parameter int SETS  = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             wr,
    input  logic [IDX_W-1:0] index,
    input  logic             valid1,
    input  logic             valid2,
    input  logic             hit1,
    input  logic             hit2,
    input  logic             done,
`ifdef VICTIM_STATS_EN
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt,
    output logic [15:0]      evict_cnt,
`endif
    output logic             victimway,
    output logic             busy,
    output logic             proto_err
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [SETS-1:0]  lru_q, lru_d;
    logic [IDX_W-1:0] idx_q, idx_d, upd_idx;
    logic             victim_q, victim_d, used_q, used_d, hit_q, hit_d, wr_q, wr_d;
    logic             proto_err_q, proto_err_d;
    logic             idle, vsel, hit_now, used_now, capture, ret_fast, ret_slow, ret_hit, ret_wr;
`ifdef VICTIM_STATS_EN
    logic             vboth_q, vboth_d, ret_evict;
    logic [15:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, evict_cnt_q, evict_cnt_d;
`endif

    always_comb begin
        idle     = state_q == IDLE;
        vsel     = ~valid1 ? 1'b0 : ~valid2 ? 1'b1 : lru_q[index];
        hit_now  = (hit1 & valid1) | (hit2 & valid2);
        used_now = (hit1 & valid1) ? 1'b0 : (hit2 & valid2) ? 1'b1 : vsel;
        capture  = idle & start & ~done;
        ret_fast = idle & start & done;
        ret_slow = ~idle & done;
        // A same-cycle retire uses live inputs; a held request uses its latched fields.
        ret_hit  = ret_fast ? hit_now : hit_q;
        ret_wr   = ret_fast ? wr : wr_q;
        upd_idx  = ret_fast ? index : idx_q;
        lru_d    = lru_q;
        if ((ret_fast | ret_slow) & (ret_hit | ~ret_wr))
            lru_d[upd_idx] = ~(ret_fast ? used_now : used_q);
        state_d     = capture ? HOLD : ret_slow ? IDLE : state_q;
        idx_d       = capture ? index : idx_q;
        victim_d    = capture ? vsel : victim_q;
        used_d      = capture ? used_now : used_q;
        hit_d       = capture ? hit_now : hit_q;
        wr_d        = capture ? wr : wr_q;
        proto_err_d = proto_err_q | (idle & done & ~start) | (~idle & start);
`ifdef VICTIM_STATS_EN
        vboth_d     = capture ? (valid1 & valid2) : vboth_q;
        ret_evict   = ~ret_wr & ~ret_hit & (ret_fast ? (valid1 & valid2) : vboth_q);
        hit_cnt_d   = hit_cnt_q + 16'((ret_fast | ret_slow) & ret_hit & ~&hit_cnt_q);
        miss_cnt_d  = miss_cnt_q + 16'((ret_fast | ret_slow) & ~ret_hit & ~&miss_cnt_q);
        evict_cnt_d = evict_cnt_q + 16'((ret_fast | ret_slow) & ret_evict & ~&evict_cnt_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lru_q       <= '0;
            idx_q       <= '0;
            victim_q    <= 1'b0;
            used_q      <= 1'b0;
            hit_q       <= 1'b0;
            wr_q        <= 1'b0;
            proto_err_q <= 1'b0;
`ifdef VICTIM_STATS_EN
            vboth_q     <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            evict_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lru_q       <= lru_d;
            idx_q       <= idx_d;
            victim_q    <= victim_d;
            used_q      <= used_d;
            hit_q       <= hit_d;
            wr_q        <= wr_d;
            proto_err_q <= proto_err_d;
`ifdef VICTIM_STATS_EN
            vboth_q     <= vboth_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            evict_cnt_q <= evict_cnt_d;
`endif
        end
    end

    assign victimway = idle ? vsel : victim_q;
    assign busy      = ~idle;
    assign proto_err = proto_err_q;
`ifdef VICTIM_STATS_EN
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign evict_cnt = evict_cnt_q;
`endif
endmodule

// File: tb/tb_victim_way_tracker.sv
// tb_victim_way_tracker: scoreboard bench for victim_way_tracker; LRU state observed through victimway.
module tb_victim_way_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, wr = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
    logic       hit1 = 1'b0, hit2 = 1'b0, done = 1'b0;
    logic [7:0] index = '0;
    logic       victimway, busy, proto_err;
`ifdef VICTIM_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, evict_cnt;
`endif
    int   tests = 0;
    int   fails = 0;
    logic m_lru [256];
    logic exp_q [$];
    logic e;

    always #5 clk = ~clk;

    victim_way_tracker #(.SETS(256), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr(wr), .index(index),
        .valid1(valid1), .valid2(valid2), .hit1(hit1), .hit2(hit2), .done(done),
`ifdef VICTIM_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt),
`endif
        .victimway(victimway), .busy(busy), .proto_err(proto_err)
    );

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic quiet();
        start = 0; done = 0; wr = 0; hit1 = 0; hit2 = 0;
    endtask

    // IDLE read-out of lru[idx]: with both ways valid and no request, victimway is the LRU bit.
    task automatic probe(input logic [7:0] idx);
        quiet();
        index = idx; valid1 = 1; valid2 = 1;
        #1;
        exp_q.push_back(m_lru[idx]);
    endtask

    task automatic test_reset();
        rst_n = 0; quiet(); index = 8'd0; valid1 = 0; valid2 = 0;
        foreach (m_lru[i]) m_lru[i] = 1'b0;
        cyc(2);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
        exp_q.push_back(1'b0); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL reset_vsel_both_invalid got=%b exp=%b", victimway, e); end
        valid1 = 1; #1; exp_q.push_back(1'b1); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL reset_vsel_way2_invalid got=%b exp=%b", victimway, e); end
        rst_n = 1;
        cyc();
        foreach (exp_q[i]) exp_q.delete(i);
        for (int k = 0; k < 3; k++) begin
            probe(k == 0 ? 8'd0 : k == 1 ? 8'd5 : 8'd255);
            e = exp_q.pop_front();
            tests++; if (victimway !== e) begin fails++; $display("FAIL reset_lru idx=%0d got=%b exp=%b", index, victimway, e); end
        end
    endtask

    task automatic test_fill();
        quiet(); index = 8'd5; valid1 = 0; valid2 = 0; start = 1;
        #1; exp_q.push_back(1'b0); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL fill_vw got=%b exp=%b", victimway, e); end
        cyc(); start = 0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL fill_busy got=%b exp=1", busy); end
        cyc(9); done = 1; cyc(); done = 0;
        m_lru[5] = 1'b1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fill_busy_after_done got=%b exp=0", busy); end
        probe(8'd5); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL fill_lru5 got=%b exp=%b", victimway, e); end
    endtask

    task automatic test_hold();
        logic v;
        quiet(); index = 8'd5; valid1 = 1; valid2 = 1; start = 1;
        v = m_lru[5];
        #1; exp_q.push_back(v); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL hold_vw_start got=%b exp=%b", victimway, e); end
        cyc(); start = 0;
        for (int k = 0; k < 12; k++) begin
            index = 8'($urandom); valid1 = 1'($urandom); valid2 = 1'($urandom);
            hit1 = 1'($urandom); hit2 = 1'($urandom);
            #1; exp_q.push_back(v); e = exp_q.pop_front();
            tests++; if (victimway !== e) begin fails++; $display("FAIL hold_vw cyc=%0d got=%b exp=%b", k, victimway, e); end
            cyc();
        end
        done = 1; cyc(); done = 0;
        m_lru[5] = ~v;
        probe(8'd5); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL hold_lru5 got=%b exp=%b", victimway, e); end
    endtask

    task automatic test_single_cycle();
        for (int k = 0; k < 2; k++) begin
            quiet(); index = 8'd9; valid1 = 1; valid2 = 1;
            hit1 = (k == 0); hit2 = (k == 1); start = 1; done = 1;
            #1; exp_q.push_back(m_lru[9]); e = exp_q.pop_front();
            tests++; if (victimway !== e) begin fails++; $display("FAIL single_vw k=%0d got=%b exp=%b", k, victimway, e); end
            cyc(); quiet();
            m_lru[9] = (k == 0) ? 1'b1 : 1'b0;
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy k=%0d got=%b exp=0", k, busy); end
            tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL single_proto_err k=%0d got=%b exp=0", k, proto_err); end
            probe(8'd9); e = exp_q.pop_front();
            tests++; if (victimway !== e) begin fails++; $display("FAIL single_lru9 k=%0d got=%b exp=%b", k, victimway, e); end
        end
    endtask

    task automatic test_store();
        // store miss (lru=0), store hit way 1, then store miss with lru=1
        for (int k = 0; k < 3; k++) begin
            quiet(); index = 8'd3; valid1 = 1; valid2 = 1; wr = 1; hit1 = (k == 1); start = 1;
            #1; exp_q.push_back(m_lru[3]); e = exp_q.pop_front();
            tests++; if (victimway !== e) begin fails++; $display("FAIL store_vw k=%0d got=%b exp=%b", k, victimway, e); end
            cyc(); start = 0; hit1 = 0;
            cyc(3); done = 1; cyc(); done = 0;
            if (k == 1) m_lru[3] = 1'b1;
            probe(8'd3); e = exp_q.pop_front();
            tests++; if (victimway !== e) begin fails++; $display("FAIL store_lru3 k=%0d got=%b exp=%b", k, victimway, e); end
        end
    endtask

    task automatic test_proto();
        quiet(); index = 8'd20; valid1 = 0; valid2 = 1; start = 1;
        #1; exp_q.push_back(1'b0); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL proto_vw_start got=%b exp=%b", victimway, e); end
        cyc();
        index = 8'd21; valid1 = 1; valid2 = 0; hit1 = 1; start = 1;
        #1; exp_q.push_back(1'b0); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL proto_vw_held got=%b exp=%b", victimway, e); end
        cyc(); quiet();
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_err_hold_start got=%b exp=1", proto_err); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL proto_busy got=%b exp=1", busy); end
        done = 1; cyc(); done = 0;
        m_lru[20] = 1'b1;
        probe(8'd20); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL proto_lru20 got=%b exp=%b", victimway, e); end
        probe(8'd21); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL proto_lru21 got=%b exp=%b", victimway, e); end
        quiet(); index = 8'd22; valid1 = 1; valid2 = 1; done = 1;
        cyc(); done = 0;
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_err_sticky got=%b exp=1", proto_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL proto_idle_done_busy got=%b exp=0", busy); end
        probe(8'd22); e = exp_q.pop_front();
        tests++; if (victimway !== e) begin fails++; $display("FAIL proto_lru22 got=%b exp=%b", victimway, e); end
    endtask

    task automatic test_reset_mid();
        quiet(); index = 8'd7; valid1 = 1; valid2 = 1; start = 1;
        cyc(); start = 0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        rst_n = 0; #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rstmid_proto_err got=%b exp=0", proto_err); end
`ifdef VICTIM_STATS_EN
        tests++; if ({hit_cnt, miss_cnt, evict_cnt} !== 48'd0) begin fails++; $display("FAIL rstmid_counters got=%h/%h/%h exp=0", hit_cnt, miss_cnt, evict_cnt); end
`endif
        foreach (m_lru[i]) m_lru[i] = 1'b0;
        cyc(); rst_n = 1; done = 1; cyc(); done = 0;
        for (int k = 0; k < 3; k++) begin
            probe(k == 0 ? 8'd7 : k == 1 ? 8'd20 : 8'd3);
            e = exp_q.pop_front();
            tests++; if (victimway !== e) begin fails++; $display("FAIL rstmid_lru idx=%0d got=%b exp=%b", index, victimway, e); end
        end
        for (int k = 0; k < 5; k++) begin
            quiet(); index = 8'(40 + k); valid1 = 1; valid2 = 1; hit1 = (k < 3); start = 1; done = 1;
            cyc();
            m_lru[40 + k] = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            probe(8'(40 + k)); e = exp_q.pop_front();
            tests++; if (victimway !== e) begin fails++; $display("FAIL stats_lru idx=%0d got=%b exp=%b", index, victimway, e); end
        end
`ifdef VICTIM_STATS_EN
        tests++; if (hit_cnt !== 16'd3) begin fails++; $display("FAIL stats_hit got=%0d exp=3", hit_cnt); end
        tests++; if (miss_cnt !== 16'd2) begin fails++; $display("FAIL stats_miss got=%0d exp=2", miss_cnt); end
        tests++; if (evict_cnt !== 16'd2) begin fails++; $display("FAIL stats_evict got=%0d exp=2", evict_cnt); end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_hold();
        test_single_cycle();
        test_store();
        test_proto();
        test_reset_mid();
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/victim_way_tracker.md
Name: victim_way_tracker

Overview:
- Per-set replacement-state keeper for the 2-way set-associative cache controller.
- Sits directly upstream of the controller's next-state logic and supplies its `victimway` input.
- Chooses the way to evict on a miss, holds that choice stable for the whole multi-cycle evict/fill sequence, and updates per-set LRU state when the request retires.
- Stores follow a write-no-allocate policy: a store miss makes no replacement-state change.

Parameters:
- SETS, 256, number of cache sets (one LRU bit per set).
- IDX_W, 8, index width; SETS = 2**IDX_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  1-cycle pulse; the controller is in its lookup cycle (LOAD/STORE) for a new request.
- wr  input  1  request is a store; sampled with start.
- index  input  IDX_W  set index of the request; sampled with start.
- valid1, valid2  input  1  way valid bits for the indexed set, current cycle.
- hit1, hit2  input  1  tag-match bits for the indexed set, current cycle.
- done  input  1  1-cycle pulse; the controller has returned to INIT and the request has retired.
- victimway  output  1  way to evict/fill: 0 = way 1, 1 = way 2.
- busy  output  1  a request is latched and awaiting done.
- proto_err  output  1  sticky flag; set on a handshake violation.

Behaviour:

Storage:
- lru[SETS-1:0]; bit = way to evict next.
- Async reset clears every bit to 0.

States: IDLE, HOLD. Reset -> IDLE.

Reset values:
- busy = 0, proto_err = 0.
- Latched fields (idx_q, victim_q, used_q, hit_q, wr_q) = 0.
- victimway follows the IDLE combinational rule.

Combinational victim selection:
- vsel = ~valid1 ? 0 : ~valid2 ? 1 : lru[index].
- Invalid way 1 wins over invalid way 2.

Hit and used way:
- hit = (hit1 & valid1) | (hit2 & valid2).
- used way = (hit1 & valid1) ? 0 : (hit2 & valid2) ? 1 : vsel.
- If both ways hit, way 1 is used.

IDLE:
- victimway = vsel, combinational, zero latency.
- The controller samples victimway in the same cycle it evaluates hit/miss.
- start & ~done: latch index->idx_q, vsel->victim_q, used way->used_q, hit->hit_q, wr->wr_q; go to HOLD; busy = 1 from the next cycle.
- start & done in the same cycle: single-cycle retire. Apply the update rule immediately using the current inputs; stay in IDLE.
- done without start: set proto_err; no update.

HOLD:
- victimway = victim_q, registered and frozen; changes on index, valid or hit inputs are ignored.
- done: apply the update rule using the latched fields; go to IDLE; busy = 0 next cycle.
- start while in HOLD: set proto_err; the request is ignored and the latched fields are unchanged.

Update rule (on retire):
- If hit_q | ~wr_q (any hit, or a load miss that filled): lru[idx_q] <= ~used_q.
- Store miss (wr_q & ~hit_q): no write.

Other rules:
- Only one array bit is written per cycle.
- No read/write collision can occur, because lookup happens only in IDLE and HOLD writes only idx_q.
- Asynchronous reset asserted mid-request: immediate return to IDLE; array and flags cleared; the pending update is dropped.
- proto_err clears only on reset.

Optional Feature:
- Macro: VICTIM_STATS_EN.
- When defined, adds three outputs: hit_cnt[15:0], miss_cnt[15:0], evict_cnt[15:0].
  - hit_cnt increments on each retire with hit.
  - miss_cnt increments on each retire without hit.
  - evict_cnt increments on each load-miss retire where both ways were valid at lookup. A valid-both flag is latched with start for this.
- All three counters saturate at 16'hFFFF, reset to 0, and are readable every cycle.
- When undefined, none of these ports or counters exist and behaviour is otherwise identical.

Test Plan:
1. Reset, then start a load (index=5, valid1=valid2=0, no hit) -> victimway = 0 in the start cycle, busy = 1 next cycle. done 10 cycles later -> lru[5] = 1, busy = 0.
2. Index 5 with valid1=valid2=1, lru[5]=1, load miss -> victimway = 1, held for 12 cycles while valid/hit/index toggle randomly. done -> lru[5] = 0.
3. Load hit on way 2 (hit2=valid2=1) at index 9 with start and done in the same cycle -> stays IDLE, lru[9] = 0, busy never asserted.
4. Store miss at index 3 (wr=1, both valid, lru[3]=0), done after 4 cycles -> lru[3] remains 0. A following store hit on way 1 -> lru[3] = 1.
5. start during HOLD -> proto_err = 1, victim_q unchanged. done in IDLE without start -> proto_err stays 1, no array write.
6. rst_n pulsed low during HOLD at index 7 -> busy = 0 immediately, lru[7] = 0, proto_err = 0. With VICTIM_STATS_EN defined, all counters = 0. Then 3 hits + 2 misses -> hit_cnt = 3, miss_cnt = 2.
